// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller (master) and the 8-bit datapath (slave).
// MemReady exists only when MULTICYCLE_CTRL_STALL_EN is defined.
interface multicycle_ctrl_if;
    logic [2:0] Op;
    logic       Zero;
`ifdef MULTICYCLE_CTRL_STALL_EN
    logic       MemReady;
`endif
    logic [1:0] ALUControl;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic [3:0] State;

    modport master (
        input  Op, Zero,
`ifdef MULTICYCLE_CTRL_STALL_EN
        input  MemReady,
`endif
        output ALUControl, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
        output IRWrite, PCWrite, MemWrite, RegWrite, State
    );

    modport slave (
        output Op, Zero,
`ifdef MULTICYCLE_CTRL_STALL_EN
        output MemReady,
`endif
        input  ALUControl, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
        input  IRWrite, PCWrite, MemWrite, RegWrite, State
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the 8-bit CPU: fetch/decode/execute/memory/writeback sequencing.
// Optional MULTICYCLE_CTRL_STALL_EN adds MemReady wait states in FETCH, MEMREAD and MEMWRITE.
module multicycle_ctrl #(
    parameter logic [1:0] ALU_AND = 2'b00,
    parameter logic [1:0] ALU_OR  = 2'b01,
    parameter logic [1:0] ALU_ADD = 2'b10,
    parameter logic [1:0] ALU_SUB = 2'b11
) (
    input  logic              clk,
    input  logic              reset_n,
    multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9
    } state_t;

    state_t state;
    state_t dec_state;
    logic   mem_ready;

`ifdef MULTICYCLE_CTRL_STALL_EN
    assign mem_ready = bus.MemReady;
`else
    assign mem_ready = 1'b1;
`endif

    // NOTE: state is sequential, so it is assigned only with <= inside always_ff.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:    if (mem_ready) state <= DECODE;
                DECODE: begin
                    case (bus.Op)
                        3'b100, 3'b101: state <= MEMADR;
                        3'b110:         state <= BRANCH;
                        3'b111:         state <= JUMP;
                        default:        state <= EXECUTE;
                    endcase
                end
                MEMADR:   state <= (bus.Op == 3'b100) ? MEMREAD : MEMWRITE;
                MEMREAD:  if (mem_ready) state <= MEMWB;
                MEMWRITE: if (mem_ready) state <= FETCH;
                EXECUTE:  state <= ALUWB;
                default:  state <= FETCH;   // MEMWB, ALUWB, BRANCH, JUMP and illegal codes
            endcase
        end
    end

    // While reset is held the datapath sees FETCH selects with all write enables off.
    assign dec_state = reset_n ? state : FETCH;

    logic [1:0] alu_control, alu_src_b, result_src;
    logic       alu_src_a, adr_src, ir_write, pc_write, mem_write, reg_write;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        alu_control = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        case (dec_state)
            FETCH: begin
                alu_src_b   = 2'b10;
                alu_control = ALU_ADD;
                result_src  = 2'b10;
                ir_write    = mem_ready;
                pc_write    = mem_ready;
            end
            DECODE: begin
                alu_src_b   = 2'b01;
                alu_control = ALU_ADD;
            end
            MEMADR: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b01;
                alu_control = ALU_ADD;
            end
            MEMREAD:  adr_src = 1'b1;
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = mem_ready;
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                case (bus.Op[1:0])
                    2'b00:   alu_control = ALU_ADD;
                    2'b01:   alu_control = ALU_SUB;
                    2'b10:   alu_control = ALU_AND;
                    default: alu_control = ALU_OR;
                endcase
            end
            ALUWB:    reg_write = 1'b1;
            BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_write    = bus.Zero;
            end
            JUMP:     pc_write = 1'b1;
            default: ;
        endcase
        if (!reset_n) begin
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign bus.ALUControl = alu_control;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ResultSrc  = result_src;
    assign bus.AdrSrc     = adr_src;
    assign bus.IRWrite    = ir_write;
    assign bus.PCWrite    = pc_write;
    assign bus.MemWrite   = mem_write;
    assign bus.RegWrite   = reg_write;
    assign bus.State      = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl: per-cycle vectors, latency sequences,
// and the MemReady stall sequence when MULTICYCLE_CTRL_STALL_EN is defined.
module tb_multicycle_ctrl;

    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    multicycle_ctrl_if bus();

    multicycle_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word: {ALUControl, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite}
    localparam logic [12:0] C_FETCH_RST = 13'b10_0_10_10_0_0_0_0_0;
    localparam logic [12:0] C_FETCH     = 13'b10_0_10_10_0_1_1_0_0;
    localparam logic [12:0] C_DECODE    = 13'b10_0_01_00_0_0_0_0_0;
    localparam logic [12:0] C_MEMADR    = 13'b10_1_01_00_0_0_0_0_0;
    localparam logic [12:0] C_MEMREAD   = 13'b00_0_00_00_1_0_0_0_0;
    localparam logic [12:0] C_MEMWB     = 13'b00_0_00_01_0_0_0_0_1;
    localparam logic [12:0] C_MEMWRITE  = 13'b00_0_00_00_1_0_0_1_0;
    localparam logic [12:0] C_EX_ADD    = 13'b10_1_00_00_0_0_0_0_0;
    localparam logic [12:0] C_EX_SUB    = 13'b11_1_00_00_0_0_0_0_0;
    localparam logic [12:0] C_EX_AND    = 13'b00_1_00_00_0_0_0_0_0;
    localparam logic [12:0] C_EX_OR     = 13'b01_1_00_00_0_0_0_0_0;
    localparam logic [12:0] C_ALUWB     = 13'b00_0_00_00_0_0_0_0_1;
    localparam logic [12:0] C_BR_TAKEN  = 13'b11_1_00_00_0_0_1_0_0;
    localparam logic [12:0] C_BR_NOT    = 13'b11_1_00_00_0_0_0_0_0;
    localparam logic [12:0] C_JUMP      = 13'b00_0_00_00_0_0_1_0_0;

    typedef struct {
        logic        rst_n;
        logic [2:0]  op;
        logic        zero;
        logic [3:0]  exp_state;
        logic [12:0] exp_ctrl;
    } vec_t;

    typedef struct {
        logic [2:0] op;
        int         cycles;
    } lat_t;

    vec_t vecs[$];
    lat_t lats[$];

    function automatic logic [12:0] ctrl_word();
        return {bus.ALUControl, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.AdrSrc,
                bus.IRWrite, bus.PCWrite, bus.MemWrite, bus.RegWrite};
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic add(input logic r, input logic [2:0] op, input logic z,
                       input logic [3:0] st, input logic [12:0] c);
        vec_t v;
        v.rst_n = r; v.op = op; v.zero = z; v.exp_state = st; v.exp_ctrl = c;
        vecs.push_back(v);
    endtask

    task automatic add_lat(input logic [2:0] op, input int cycles);
        lat_t l;
        l.op = op; l.cycles = cycles;
        lats.push_back(l);
    endtask

    initial begin
        int cycles;

        // Reset held, then released: first post-reset cycle fetches.
        add(0, 3'b000, 0, 4'd0, C_FETCH_RST);
        add(1, 3'b000, 0, 4'd0, C_FETCH);
        // SUB, ADD, AND, OR (Zero toggled where it must not matter)
        add(1, 3'b001, 0, 4'd1, C_DECODE);
        add(1, 3'b001, 1, 4'd6, C_EX_SUB);
        add(1, 3'b111, 0, 4'd7, C_ALUWB);
        add(1, 3'b000, 0, 4'd0, C_FETCH);
        add(1, 3'b000, 0, 4'd1, C_DECODE);
        add(1, 3'b000, 0, 4'd6, C_EX_ADD);
        add(1, 3'b000, 0, 4'd7, C_ALUWB);
        add(1, 3'b010, 0, 4'd0, C_FETCH);
        add(1, 3'b010, 0, 4'd1, C_DECODE);
        add(1, 3'b010, 0, 4'd6, C_EX_AND);
        add(1, 3'b010, 0, 4'd7, C_ALUWB);
        add(1, 3'b011, 0, 4'd0, C_FETCH);
        add(1, 3'b011, 0, 4'd1, C_DECODE);
        add(1, 3'b011, 0, 4'd6, C_EX_OR);
        add(1, 3'b011, 0, 4'd7, C_ALUWB);
        // LOAD (Op changes after MEMADR; it is a don't-care there)
        add(1, 3'b100, 0, 4'd0, C_FETCH);
        add(1, 3'b100, 0, 4'd1, C_DECODE);
        add(1, 3'b100, 0, 4'd2, C_MEMADR);
        add(1, 3'b001, 0, 4'd3, C_MEMREAD);
        add(1, 3'b001, 0, 4'd4, C_MEMWB);
        // STORE: MemWrite only in MEMWRITE
        add(1, 3'b101, 0, 4'd0, C_FETCH);
        add(1, 3'b101, 0, 4'd1, C_DECODE);
        add(1, 3'b101, 0, 4'd2, C_MEMADR);
        add(1, 3'b101, 0, 4'd5, C_MEMWRITE);
        // BEQ taken / not taken
        add(1, 3'b110, 1, 4'd0, C_FETCH);
        add(1, 3'b110, 1, 4'd1, C_DECODE);
        add(1, 3'b110, 1, 4'd8, C_BR_TAKEN);
        add(1, 3'b110, 0, 4'd0, C_FETCH);
        add(1, 3'b110, 0, 4'd1, C_DECODE);
        add(1, 3'b110, 0, 4'd8, C_BR_NOT);
        // JMP
        add(1, 3'b111, 0, 4'd0, C_FETCH);
        add(1, 3'b111, 0, 4'd1, C_DECODE);
        add(1, 3'b111, 0, 4'd9, C_JUMP);
        // LOAD aborted by reset in MEMREAD: never reaches MEMWB
        add(1, 3'b100, 0, 4'd0, C_FETCH);
        add(1, 3'b100, 0, 4'd1, C_DECODE);
        add(1, 3'b100, 0, 4'd2, C_MEMADR);
        add(0, 3'b100, 0, 4'd3, C_FETCH_RST);
        add(1, 3'b000, 0, 4'd0, C_FETCH);
        add(1, 3'b000, 0, 4'd1, C_DECODE);

        add_lat(3'b000, 4); add_lat(3'b001, 4); add_lat(3'b010, 4); add_lat(3'b011, 4);
        add_lat(3'b100, 5); add_lat(3'b101, 4); add_lat(3'b110, 3); add_lat(3'b111, 3);

        reset_n = 1'b0;
        bus.Op   = 3'b000;
        bus.Zero = 1'b0;
`ifdef MULTICYCLE_CTRL_STALL_EN
        bus.MemReady = 1'b1;
`endif
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset_n  = vecs[i].rst_n;
            bus.Op   = vecs[i].op;
            bus.Zero = vecs[i].zero;
            #1;
            check($sformatf("vec%0d state", i), 32'(bus.State), 32'(vecs[i].exp_state));
            check($sformatf("vec%0d ctrl", i), 32'(ctrl_word()), 32'(vecs[i].exp_ctrl));
        end

        // Latency: cycles from FETCH until FETCH again, bounded.
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1; bus.Zero = 1'b0;
        #1;
        check("latency start state", 32'(bus.State), 32'd0);
        foreach (lats[i]) begin
            bus.Op = lats[i].op;
            cycles = 0;
            do begin
                @(negedge clk); #1;
                cycles++;
            end while (bus.State != 4'd0 && cycles < 10);
            check($sformatf("latency op%0b", lats[i].op), 32'(cycles), 32'(lats[i].cycles));
        end

`ifdef MULTICYCLE_CTRL_STALL_EN
        // Stall three cycles in FETCH, then release.
        bus.Op = 3'b000;
        bus.MemReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("stall%0d state", k), 32'(bus.State), 32'd0);
            check($sformatf("stall%0d ctrl", k), 32'(ctrl_word()), 32'(C_FETCH_RST));
            @(negedge clk); #1;
        end
        check("stall held state", 32'(bus.State), 32'd0);
        bus.MemReady = 1'b1;
        #1;
        check("stall release ctrl", 32'(ctrl_word()), 32'(C_FETCH));
        @(negedge clk); #1;
        check("stall release state", 32'(bus.State), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
